pc_trace_checker: RTL and testbench

- Synthesizable successor to the processor bench's fixed-array address checker. Holds a loadable table of expected instruction addresses, compares each fetched address from the Processor's InstAdd against it, and counts and captures mismatches.
- Also generates a programmable IRQ pulse at a chosen step.
- Sits beside Processor in simulation and on FPGA self-test builds.

---
 rtl/pc_trace_checker.sv | 200 ++++++++++++++++++++
 tb/tb_pc_trace_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_checker.sv
// pc_trace_checker
// Checks the Processor's fetched instruction addresses against a loadable
// table of expected addresses. Mismatches are counted (saturating) and the
// first one is captured. The block can also raise a programmable IRQ pulse
// at a chosen step of the trace.
module pc_trace_checker #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int CNT_W  = 16,
  parameter int IRQ_W  = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [ADDR_W-1:0] ld_data,
  input  logic [IDX_W:0]    trace_len,
  input  logic              start,
  input  logic              step_valid,
  input  logic [ADDR_W-1:0] InstAdd,
  input  logic [IDX_W-1:0]  irq_step,
  input  logic [IRQ_W-1:0]  irq_len,
  output logic              IRQ,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [ADDR_W-1:0] first_err_exp,
  output logic [ADDR_W-1:0] first_err_act,
  output logic [IDX_W:0]    cur_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_L   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   IDX_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ADDR_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IRQ_W-1:0] PULSE_ONE = IRQ_W'(1);

  state_t state;
  state_t state_nxt;

  // Expected-trace storage; intentionally not reset so it survives a reset.
  logic [ADDR_W-1:0] trace_mem [DEPTH];
  logic [ADDR_W-1:0] rd_data;
  logic [IDX_W-1:0]  rd_addr;
  logic              wr_en;

  // Run parameters latched on start.
  logic [IDX_W:0]    len_q;
  logic [IDX_W-1:0]  irq_step_q;
  logic [IRQ_W-1:0]  irq_len_q;

  logic              captured;
  logic              irq_fired;
  logic [IRQ_W-1:0]  irq_cnt;

  logic              step_fire;
  logic              mismatch;
  logic              last_step;
  logic              irq_hit;
  logic [IDX_W:0]    idx_inc;
  logic [IDX_W:0]    len_eff;

  // start always wins over a step arriving in the same cycle.
  assign step_fire = (state == RUN) && step_valid && !start;
  assign mismatch  = step_fire && (InstAdd != rd_data);
  assign idx_inc   = cur_idx + IDX_ONE;
  assign last_step = step_fire && (idx_inc == len_q);
  assign wr_en     = (state == IDLE) && ld_en;

  // Zero or oversized lengths mean "check the whole table".
  assign len_eff = ((trace_len == '0) || (trace_len > DEPTH_L)) ? DEPTH_L : trace_len;

  assign irq_hit = step_fire && !irq_fired && (irq_len_q != '0) &&
                   (cur_idx == {1'b0, irq_step_q});

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_count == '0);

  // Read address is the index the next cycle will compare against, so the
  // registered table read always lines up with cur_idx without bubbles.
  always_comb begin
    rd_addr = cur_idx[IDX_W-1:0];
    if (start) begin
      rd_addr = '0;
    end else if (step_fire) begin
      rd_addr = cur_idx[IDX_W-1:0] + ADDR_ONE;
    end
  end

  // Table write port and prefetching read register, with write-through
  // bypass so a load to the address being read is seen immediately.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      trace_mem[ld_idx] <= ld_data;
    end
    if (wr_en && (ld_idx == rd_addr)) begin
      rd_data <= ld_data;
    end else begin
      rd_data <= trace_mem[rd_addr];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; IDLE is only re-entered through reset.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (start) begin
          state_nxt = RUN;
        end else if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping: step index, error counter and first-mismatch capture.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cur_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      captured      <= 1'b0;
      len_q         <= '0;
      irq_step_q    <= '0;
      irq_len_q     <= '0;
    end else if (start) begin
      cur_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      captured      <= 1'b0;
      len_q         <= len_eff;
      irq_step_q    <= irq_step;
      irq_len_q     <= irq_len;
    end else if (step_fire) begin
      cur_idx <= idx_inc;
      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_ONE;
        end
        if (!captured) begin
          captured      <= 1'b1;
          first_err_idx <= cur_idx[IDX_W-1:0];
          first_err_exp <= rd_data;
          first_err_act <= InstAdd;
        end
      end
    end
  end

  // IRQ pulse generator: one pulse per run, length counted in clocks and
  // independent of step_valid or the run ending; a new start cuts it short.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      IRQ       <= 1'b0;
      irq_cnt   <= '0;
      irq_fired <= 1'b0;
    end else if (start) begin
      IRQ       <= 1'b0;
      irq_cnt   <= '0;
      irq_fired <= 1'b0;
    end else if (IRQ) begin
      if (irq_cnt == PULSE_ONE) begin
        IRQ <= 1'b0;
      end
      irq_cnt <= irq_cnt - PULSE_ONE;
    end else if (irq_hit) begin
      IRQ       <= 1'b1;
      irq_cnt   <= irq_len_q;
      irq_fired <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_trace_checker.sv
// Directed testbench for pc_trace_checker. A second instance with a 2-bit
// error counter shares all inputs and is used for the saturation scenario.
module tb_pc_trace_checker;

  logic        clk = 1'b0;
  logic        RESET;
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;
  logic [10:0] trace_len;
  logic        start;
  logic        step_valid;
  logic [31:0] InstAdd;
  logic [9:0]  irq_step;
  logic [7:0]  irq_len;

  logic        IRQ, busy, done, pass;
  logic [15:0] err_count;
  logic [9:0]  first_err_idx;
  logic [31:0] first_err_exp, first_err_act;
  logic [10:0] cur_idx;

  logic        s_irq, s_busy, s_done, s_pass;
  logic [1:0]  s_err_count;
  logic [9:0]  s_first_err_idx;
  logic [31:0] s_first_err_exp, s_first_err_act;
  logic [10:0] s_cur_idx;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_tab [6] = '{32'h8000_0000, 32'h8000_002C, 32'h8000_0030,
                               32'h8000_0034, 32'h8000_0038, 32'h8000_003C};

  pc_trace_checker u_dut (
    .clk(clk), .RESET(RESET), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .trace_len(trace_len), .start(start), .step_valid(step_valid), .InstAdd(InstAdd),
    .irq_step(irq_step), .irq_len(irq_len), .IRQ(IRQ), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act), .cur_idx(cur_idx)
  );

  pc_trace_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .RESET(RESET), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .trace_len(trace_len), .start(start), .step_valid(step_valid), .InstAdd(InstAdd),
    .irq_step(irq_step), .irq_len(irq_len), .IRQ(s_irq), .busy(s_busy), .done(s_done),
    .pass(s_pass), .err_count(s_err_count), .first_err_idx(s_first_err_idx),
    .first_err_exp(s_first_err_exp), .first_err_act(s_first_err_act), .cur_idx(s_cur_idx)
  );

  always #5 clk = ~clk;

  task automatic load_entry(input logic [9:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic begin_run(input logic [10:0] len, input logic [9:0] istep, input logic [7:0] ilen);
    trace_len = len; irq_step = istep; irq_len = ilen; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_step(input logic [31:0] addr, input logic valid);
    step_valid = valid; InstAdd = addr;
    @(posedge clk); #1;
    step_valid = 1'b0; InstAdd = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; ld_en = 0; ld_idx = 0; ld_data = 0; trace_len = 0; start = 0;
    step_valid = 0; InstAdd = 0; irq_step = 0; irq_len = 0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0h expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %0h expected 0", pass); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %0h expected 0", IRQ); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_err: got %0h expected 0", err_count); end
    checks++; if (cur_idx !== 11'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0h expected 0", cur_idx); end
    RESET = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass_run();
    for (int i = 0; i < 6; i++) load_entry(10'(i), exp_tab[i]);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0h expected 0", busy); end
    begin_run(11'd5, 10'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      do_step(exp_tab[i], 1'b1);
      if (i == 3) begin
        checks++; if (cur_idx !== 11'd4) begin errors++; $display("[TB] FAIL pass_mididx: got %0h expected 4", cur_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL pass_early_done: got %0h expected 0", done); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL pass_done: got %0h expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pass_busy: got %0h expected 0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL pass_pass: got %0h expected 1", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL pass_err: got %0h expected 0", err_count); end
    checks++; if (cur_idx !== 11'd5) begin errors++; $display("[TB] FAIL pass_idx: got %0h expected 5", cur_idx); end
    // Steps after DONE must be ignored.
    do_step(32'hDEAD_BEEF, 1'b1);
    checks++; if (err_count !== 16'd0 || cur_idx !== 11'd5) begin errors++; $display("[TB] FAIL done_ignore: got err %0h idx %0h expected 0 5", err_count, cur_idx); end
  endtask

  task automatic test_mismatch();
    logic [31:0] drv [5];
    drv = '{32'h8000_0000, 32'h8000_002C, 32'h8000_0004, 32'h8000_0034, 32'h8000_0008};
    begin_run(11'd5, 10'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin ld_en = 1'b1; ld_idx = 10'd3; ld_data = 32'hDEAD_0000; end
      do_step(drv[i], 1'b1);
      ld_en = 1'b0;
      if (i == 2) begin
        checks++; if (err_count !== 16'd1) begin errors++; $display("[TB] FAIL mm_err_step2: got %0h expected 1", err_count); end
      end
    end
    checks++; if (err_count !== 16'd2) begin errors++; $display("[TB] FAIL mm_err: got %0h expected 2", err_count); end
    checks++; if (first_err_idx !== 10'd2) begin errors++; $display("[TB] FAIL mm_idx: got %0h expected 2", first_err_idx); end
    checks++; if (first_err_exp !== 32'h8000_0030) begin errors++; $display("[TB] FAIL mm_exp: got %0h expected 80000030", first_err_exp); end
    checks++; if (first_err_act !== 32'h8000_0004) begin errors++; $display("[TB] FAIL mm_act: got %0h expected 80000004", first_err_act); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL mm_pass: got pass %0h done %0h expected 0 1", pass, done); end
  endtask

  task automatic test_toggle();
    begin_run(11'd4, 10'd0, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 0) do_step(exp_tab[(i/2)-1], 1'b1);
      else do_step(32'hFFFF_FFFF, 1'b0);
      if (i == 1) begin
        checks++; if (cur_idx !== 11'd0) begin errors++; $display("[TB] FAIL tog_hold: got %0h expected 0", cur_idx); end
      end
      if (i == 7) begin
        checks++; if (done !== 1'b0 || cur_idx !== 11'd3) begin errors++; $display("[TB] FAIL tog_c7: got done %0h idx %0h expected 0 3", done, cur_idx); end
      end
    end
    checks++; if (done !== 1'b1 || cur_idx !== 11'd4) begin errors++; $display("[TB] FAIL tog_c8: got done %0h idx %0h expected 1 4", done, cur_idx); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL tog_err: got %0h expected 0", err_count); end
  endtask

  task automatic test_irq();
    logic seen;
    begin_run(11'd5, 10'd3, 8'd2);
    for (int i = 0; i < 4; i++) begin
      do_step(exp_tab[i], 1'b1);
      if (i == 2) begin
        checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_before: got %0h expected 0", IRQ); end
      end
    end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL irq_c1: got %0h expected 1", IRQ); end
    do_step(32'h0, 1'b0);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL irq_c2: got %0h expected 1", IRQ); end
    do_step(32'h0, 1'b0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_c3: got %0h expected 0", IRQ); end
    do_step(exp_tab[4], 1'b1);
    checks++; if (done !== 1'b1 || err_count !== 16'd0) begin errors++; $display("[TB] FAIL irq_run: got done %0h err %0h expected 1 0", done, err_count); end
    // irq_len of zero disables the pulse.
    begin_run(11'd5, 10'd0, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin do_step(exp_tab[i], 1'b1); seen |= IRQ; end
    do_step(32'h0, 1'b0); seen |= IRQ;
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL irq_len0: got %0h expected 0", seen); end
    // Pulse started on the last step completes after DONE.
    begin_run(11'd5, 10'd4, 8'd3);
    for (int i = 0; i < 5; i++) do_step(exp_tab[i], 1'b1);
    checks++; if (IRQ !== 1'b1 || done !== 1'b1) begin errors++; $display("[TB] FAIL irq_end_c1: got irq %0h done %0h expected 1 1", IRQ, done); end
    do_step(32'h0, 1'b0);
    do_step(32'h0, 1'b0);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL irq_end_c3: got %0h expected 1", IRQ); end
    do_step(32'h0, 1'b0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_end_off: got %0h expected 0", IRQ); end
    // A restart truncates an active pulse and clears the run.
    begin_run(11'd5, 10'd0, 8'd5);
    do_step(32'h1111_1111, 1'b1);
    checks++; if (IRQ !== 1'b1 || err_count !== 16'd1) begin errors++; $display("[TB] FAIL irq_trunc_pre: got irq %0h err %0h expected 1 1", IRQ, err_count); end
    begin_run(11'd5, 10'd0, 8'd0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_trunc: got %0h expected 0", IRQ); end
    checks++; if (busy !== 1'b1 || cur_idx !== 11'd0 || err_count !== 16'd0) begin errors++; $display("[TB] FAIL restart_clear: got busy %0h idx %0h err %0h expected 1 0 0", busy, cur_idx, err_count); end
  endtask

  task automatic test_boundary_len();
    logic [10:0] lens [2];
    lens = '{11'd0, 11'd1500};
    for (int k = 0; k < 2; k++) begin
      begin_run(lens[k], 10'd0, 8'd0);
      for (int i = 0; i < 1024; i++) begin
        do_step(32'h8000_0000, 1'b1);
        if (i == 1022) begin
          checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL len%0d_early: got %0h expected 0", k, done); end
        end
      end
      checks++; if (done !== 1'b1 || cur_idx !== 11'd1024) begin errors++; $display("[TB] FAIL len%0d_full: got done %0h idx %0h expected 1 400", k, done, cur_idx); end
    end
  endtask

  task automatic test_saturation();
    begin_run(11'd6, 10'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      do_step(32'h0, 1'b1);
      if (i == 2) begin
        checks++; if (s_err_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_three: got %0h expected 3", s_err_count); end
      end
    end
    checks++; if (s_err_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_stick: got %0h expected 3", s_err_count); end
    checks++; if (err_count !== 16'd6) begin errors++; $display("[TB] FAIL sat_wide: got %0h expected 6", err_count); end
    checks++; if (first_err_idx !== 10'd0 || first_err_exp !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sat_first: got idx %0h exp %0h expected 0 80000000", first_err_idx, first_err_exp); end
    checks++; if (s_done !== 1'b1) begin errors++; $display("[TB] FAIL sat_done: got %0h expected 1", s_done); end
  endtask

  task automatic test_reset_mid_run();
    begin_run(11'd5, 10'd1, 8'd10);
    do_step(exp_tab[0], 1'b1);
    do_step(32'h0000_1234, 1'b1);
    do_step(exp_tab[2], 1'b1);
    checks++; if (IRQ !== 1'b1 || err_count !== 16'd1) begin errors++; $display("[TB] FAIL rst_pre: got irq %0h err %0h expected 1 1", IRQ, err_count); end
    #2 RESET = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_state: got busy %0h done %0h expected 0 0", busy, done); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq: got %0h expected 0", IRQ); end
    checks++; if (err_count !== 16'd0 || cur_idx !== 11'd0 || first_err_idx !== 10'd0) begin errors++; $display("[TB] FAIL rst_regs: got err %0h idx %0h fidx %0h expected 0 0 0", err_count, cur_idx, first_err_idx); end
    #2 RESET = 1'b1;
    @(posedge clk); #1;
    begin_run(11'd5, 10'd0, 8'd0);
    for (int i = 0; i < 5; i++) do_step(exp_tab[i], 1'b1);
    checks++; if (pass !== 1'b1 || err_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_rerun: got pass %0h err %0h expected 1 0", pass, err_count); end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_mismatch();
    test_toggle();
    test_irq();
    test_boundary_len();
    test_saturation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
